cbuf_event_dispatcher: RTL and testbench



---
 rtl/cbuf_dispatch_pkg.sv | 68 ++++++
 rtl/event_seq_checker.sv | 50 +++++
 rtl/cbuf_event_dispatcher.sv | 224 ++++++++++++++++++++++
 tb/tb_cbuf_event_dispatcher.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbuf_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// cbuf_dispatch_pkg
//
// Shared definitions for the circular-buffer event dispatcher:
//   - state index constants and the one-hot state type
//   - bit positions / widths of the acquisition event word and of the
//     64-bit trigger-information record
//   - DUR_MAX, the saturation value of the readout duration counter
//   - pack_record(), the single place where the record layout is assembled
// -----------------------------------------------------------------------------
package cbuf_dispatch_pkg;

    // One-hot state bit indices (also the bit order of the 'state' port).
    localparam int ST_IDLE    = 0;
    localparam int ST_READOUT = 1;
    localparam int ST_EMIT    = 2;
    localparam int STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'b001,
        S_READOUT = 3'b010,
        S_EMIT    = 3'b100
    } state_t;

    // Acquisition event word fields.
    localparam int EVT_W         = 32;
    localparam int EVT_TYPE_LSB  = 24;
    localparam int EVT_TYPE_W    = 5;
    localparam int EVT_NUM_LSB   = 0;
    localparam int EVT_NUM_W     = 24;

    // Trigger-information record fields.
    localparam int REC_W           = 64;
    localparam int REC_TIMEOUT_BIT = 63;
    localparam int REC_SEQ_GAP_BIT = 62;
    localparam int REC_MASK_LSB    = 57;
    localparam int REC_MASK_W      = 5;
    localparam int REC_TYPE_LSB    = 52;
    localparam int REC_TYPE_W      = 5;
    localparam int REC_NUM_LSB     = 28;
    localparam int REC_NUM_W       = 24;
    localparam int REC_DUR_LSB     = 0;
    localparam int REC_DUR_W       = 28;

    localparam logic [REC_DUR_W-1:0] DUR_MAX = 28'hFFF_FFFF;

    localparam int EVT_COUNT_W = 24;

    function automatic logic [REC_W-1:0] pack_record(
        input logic                  timed_out,
        input logic                  seq_gap,
        input logic [REC_MASK_W-1:0] mask,
        input logic [REC_TYPE_W-1:0] trig_type,
        input logic [REC_NUM_W-1:0]  trig_num,
        input logic [REC_DUR_W-1:0]  dur
    );
        logic [REC_W-1:0] rec;
        rec = '0;
        rec[REC_TIMEOUT_BIT]                        = timed_out;
        rec[REC_SEQ_GAP_BIT]                        = seq_gap;
        rec[REC_MASK_LSB +: REC_MASK_W]             = mask;
        rec[REC_TYPE_LSB +: REC_TYPE_W]             = trig_type;
        rec[REC_NUM_LSB  +: REC_NUM_W]              = trig_num;
        rec[REC_DUR_LSB  +: REC_DUR_W]              = dur;
        return rec;
    endfunction

endpackage

// File: rtl/event_seq_checker.sv
// -----------------------------------------------------------------------------
// event_seq_checker
//
// Trigger-number continuity check. Remembers the trig_num of the last checked
// event and flags a gap when the next one is not previous + 1 (mod 2^24).
// The first event after reset or after 'clear' only arms the checker.
//
// Ports:
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset (disarms the checker)
//   check     in   strobe: trig_num is a new event to be checked and stored
//   clear     in   disarm; the next checked event is not compared
//   trig_num  in   trigger number of the event being popped
//   gap       out  combinational: trig_num breaks the sequence (valid with check)
// -----------------------------------------------------------------------------
module event_seq_checker
    import cbuf_dispatch_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 check,
    input  logic                 clear,
    input  logic [REC_NUM_W-1:0] trig_num,
    output logic                 gap
);

    logic                 armed_reg;
    logic [REC_NUM_W-1:0] prev_num_reg;
    logic [REC_NUM_W-1:0] expected_num;

    // 24-bit add wraps naturally, so 0xFFFFFF -> 0x000000 is in sequence.
    assign expected_num = prev_num_reg + REC_NUM_W'(1);

    // A clear arriving together with an event makes that event the first
    // one of a fresh sequence, so it is not compared.
    assign gap = armed_reg && !clear && (trig_num != expected_num);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_reg    <= 1'b0;
            prev_num_reg <= '0;
        end else if (check) begin
            armed_reg    <= 1'b1;
            prev_num_reg <= trig_num;
        end else if (clear) begin
            armed_reg    <= 1'b0;
        end
    end

endmodule

// File: rtl/cbuf_event_dispatcher.sv
// -----------------------------------------------------------------------------
// cbuf_event_dispatcher
//
// Pops acquisition event words from a first-word-fall-through FIFO, requests
// readout from the enabled channel FPGAs, waits for all of them (or a
// timeout), then emits one 64-bit trigger-information record downstream.
// Keeps sticky timeout / sequence-gap flags and a count of delivered records.
//
// Build option:
//   SEQ_CHECK_EN  defined   -> trigger-number continuity check is built
//                 undefined -> record bit 62 and seq_err are constant 0
//
// Ports:
//   clk              in   40 MHz TTC clock
//   reset_n          in   asynchronous active-low reset
//   chan_en          in   [NCHAN]   channels to read out, sampled at pop
//   readout_timeout  in   [TIMEOUT_W] max READOUT cycles, 0 = no timeout
//   evt_valid        in   event FIFO not empty
//   evt_data         in   [32] {ignored[31:29], trig_type[28:24], trig_num[23:0]}
//   evt_ready        out  single-cycle pop strobe
//   rd_req           out  [NCHAN]   per-channel readout request (level)
//   rd_done          in   [NCHAN]   per-channel readout done (level)
//   info_valid       out  record valid
//   info_data        out  [64] {timed_out, seq_gap, mask[5], type[5], num[24], dur[28]}
//   info_ready       in   downstream accepts record
//   err_clear        in   clear sticky errors, re-arm sequence check
//   seq_err          out  sticky trigger-number gap
//   timeout_err      out  sticky readout timeout
//   evt_count        out  [24] records accepted downstream (wraps)
//   state            out  [3] one-hot {EMIT, READOUT, IDLE}
// -----------------------------------------------------------------------------
module cbuf_event_dispatcher
    import cbuf_dispatch_pkg::*;
#(
    parameter int NCHAN     = 5,
    parameter int TIMEOUT_W = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NCHAN-1:0]       chan_en,
    input  logic [TIMEOUT_W-1:0]   readout_timeout,
    input  logic                   evt_valid,
    input  logic [EVT_W-1:0]       evt_data,
    output logic                   evt_ready,
    output logic [NCHAN-1:0]       rd_req,
    input  logic [NCHAN-1:0]       rd_done,
    output logic                   info_valid,
    output logic [REC_W-1:0]       info_data,
    input  logic                   info_ready,
    input  logic                   err_clear,
    output logic                   seq_err,
    output logic                   timeout_err,
    output logic [EVT_COUNT_W-1:0] evt_count,
    output logic [STATE_W-1:0]     state
);

    // Common width for comparing the duration counter with the timeout.
    localparam int CMP_W = (TIMEOUT_W > REC_DUR_W) ? TIMEOUT_W : REC_DUR_W;

    state_t                  state_reg;
    logic [NCHAN-1:0]        en_reg;
    logic [NCHAN-1:0]        rd_req_reg;
    logic [NCHAN-1:0]        mask_reg;
    logic [REC_TYPE_W-1:0]   type_reg;
    logic [REC_NUM_W-1:0]    num_reg;
    logic [REC_DUR_W-1:0]    dur_reg;
    logic                    timed_out_reg;
    logic                    seq_gap_reg;
    logic                    timeout_err_reg;
    logic [EVT_COUNT_W-1:0]  evt_count_reg;

    logic                    pop;
    logic                    seq_gap;
    logic [NCHAN-1:0]        chan_ok;
    logic                    all_done;
    logic                    tmo_hit;
    logic                    timeout_exit;
    logic [REC_DUR_W-1:0]    dur_next;
    logic [REC_MASK_W-1:0]   mask_field;
    logic                    unused_evt_bits;

    // Upper event-word bits carry no information for this block.
    assign unused_evt_bits = ^evt_data[EVT_W-1:EVT_TYPE_LSB+EVT_TYPE_W];

    // Pop only from IDLE; gated by reset_n so no word is consumed while the
    // state machine is held in reset.
    assign pop       = (state_reg == S_IDLE) && evt_valid && reset_n;
    assign evt_ready = pop;

    // A channel is satisfied when it is not enabled or reports done.
    genvar gi;
    generate
        for (gi = 0; gi < NCHAN; gi++) begin : g_chan_ok
            assign chan_ok[gi] = ~en_reg[gi] | rd_done[gi];
        end
    endgenerate
    assign all_done = &chan_ok;

    // dur counts completed READOUT cycles; in READOUT cycle n it holds n-1,
    // so matching timeout-1 exits after exactly 'readout_timeout' cycles.
    assign tmo_hit = (readout_timeout != '0) &&
                     (CMP_W'(dur_reg) == (CMP_W'(readout_timeout) - CMP_W'(1)));

    // Completion has priority over a timeout hit in the same cycle.
    assign timeout_exit = (state_reg == S_READOUT) && tmo_hit && !all_done;

    assign dur_next = (dur_reg == DUR_MAX) ? dur_reg : dur_reg + REC_DUR_W'(1);

    // The record mask field is fixed at 5 bits regardless of NCHAN.
    generate
        for (gi = 0; gi < REC_MASK_W; gi++) begin : g_mask_field
            if (gi < NCHAN) begin : g_used
                assign mask_field[gi] = mask_reg[gi];
            end else begin : g_pad
                assign mask_field[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef SEQ_CHECK_EN
    logic seq_err_reg;

    event_seq_checker u_seq_checker (
        .clk      (clk),
        .reset_n  (reset_n),
        .check    (pop),
        .clear    (err_clear),
        .trig_num (evt_data[EVT_NUM_LSB +: EVT_NUM_W]),
        .gap      (seq_gap)
    );

    // A new gap in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_err_reg <= 1'b0;
        end else begin
            seq_err_reg <= (seq_err_reg & ~err_clear) | (pop & seq_gap);
        end
    end

    assign seq_err = seq_err_reg;
`else
    assign seq_gap = 1'b0;
    assign seq_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= (timeout_err_reg & ~err_clear) | timeout_exit;
        end
    end

    // Main control FSM; every output-facing field is a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            en_reg        <= '0;
            rd_req_reg    <= '0;
            mask_reg      <= '0;
            type_reg      <= '0;
            num_reg       <= '0;
            dur_reg       <= '0;
            timed_out_reg <= 1'b0;
            seq_gap_reg   <= 1'b0;
            evt_count_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pop) begin
                        type_reg      <= evt_data[EVT_TYPE_LSB +: EVT_TYPE_W];
                        num_reg       <= evt_data[EVT_NUM_LSB +: EVT_NUM_W];
                        en_reg        <= chan_en;
                        dur_reg       <= '0;
                        mask_reg      <= '0;
                        timed_out_reg <= 1'b0;
                        seq_gap_reg   <= seq_gap;
                        if (chan_en == '0) begin
                            // Nothing to read out: go straight to EMIT.
                            state_reg  <= S_EMIT;
                        end else begin
                            rd_req_reg <= chan_en;
                            state_reg  <= S_READOUT;
                        end
                    end
                end

                S_READOUT: begin
                    dur_reg <= dur_next;
                    if (all_done || tmo_hit) begin
                        mask_reg      <= rd_done & en_reg;
                        timed_out_reg <= !all_done;
                        rd_req_reg    <= '0;
                        state_reg     <= S_EMIT;
                    end
                end

                S_EMIT: begin
                    if (info_ready) begin
                        evt_count_reg <= evt_count_reg + EVT_COUNT_W'(1);
                        state_reg     <= S_IDLE;
                    end
                end

                default: begin
                    rd_req_reg <= '0;
                    state_reg  <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_req      = rd_req_reg;
    assign info_valid  = (state_reg == S_EMIT);
    // Built purely from registers that are frozen in EMIT, so the record is
    // stable for as long as the downstream stalls.
    assign info_data   = pack_record(timed_out_reg, seq_gap_reg, mask_field,
                                     type_reg, num_reg, dur_reg);
    assign timeout_err = timeout_err_reg;
    assign evt_count   = evt_count_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_cbuf_event_dispatcher.sv
`timescale 1ns/1ps
module tb_cbuf_event_dispatcher;

    localparam int NCHAN     = 5;
    localparam int TIMEOUT_W = 24;
`ifdef SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NCHAN-1:0]     chan_en = '0;
    logic [TIMEOUT_W-1:0] readout_timeout = '0;
    logic                 evt_valid = 1'b0;
    logic [31:0]          evt_data = '0;
    logic                 evt_ready;
    logic [NCHAN-1:0]     rd_req;
    logic [NCHAN-1:0]     rd_done = '0;
    logic                 info_valid;
    logic [63:0]          info_data;
    logic                 info_ready = 1'b0;
    logic                 err_clear = 1'b0;
    logic                 seq_err;
    logic                 timeout_err;
    logic [23:0]          evt_count;
    logic [2:0]           state;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic        armed_m = 1'b0;
    logic [23:0] prev_m = '0;
    logic        seq_err_m = 1'b0;
    logic        to_err_m = 1'b0;
    logic [23:0] count_m = '0;

    cbuf_event_dispatcher #(.NCHAN(NCHAN), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk(clk), .reset_n(reset_n), .chan_en(chan_en),
        .readout_timeout(readout_timeout), .evt_valid(evt_valid),
        .evt_data(evt_data), .evt_ready(evt_ready), .rd_req(rd_req),
        .rd_done(rd_done), .info_valid(info_valid), .info_data(info_data),
        .info_ready(info_ready), .err_clear(err_clear), .seq_err(seq_err),
        .timeout_err(timeout_err), .evt_count(evt_count), .state(state)
    );

    always #5 clk = ~clk;

    // Sequence rule: expected number is previous + 1 mod 2^24; first after
    // reset/clear is only remembered.
    function automatic logic seq_step(input logic [23:0] num);
        logic g;
        logic [23:0] exp_num;
        exp_num = prev_m + 24'd1;
        g = SEQ_ON && armed_m && (num != exp_num);
        armed_m = 1'b1;
        prev_m  = num;
        if (g) seq_err_m = 1'b1;
        return g;
    endfunction

    function automatic void model_reset();
        armed_m = 1'b0; seq_err_m = 1'b0; to_err_m = 1'b0; count_m = '0;
    endfunction

    // One complete event: pop, readout with rd_done = dmask from READOUT cycle k,
    // optional err_clear in READOUT cycle clr_cyc, backpressure 'hold' cycles.
    task automatic run_event(input logic [31:0] word, input logic [4:0] en,
                             input logic [23:0] tmo, input logic [4:0] dmask,
                             input int k, input int hold, input int clr_cyc,
                             input string tag);
        logic        gap_e, to_e;
        logic [4:0]  mask_e;
        logic [27:0] dur_e;
        logic [63:0] rec_e;
        int c_done, c_to, c_exit, i;
        bit got;

        gap_e = seq_step(word[23:0]);
        if (en == 5'd0) begin
            to_e = 1'b0; mask_e = 5'd0; c_exit = 0;
        end else begin
            c_done = ((dmask & en) == en) ? k : (1 << 30);
            c_to   = (tmo != 24'd0) ? int'(tmo) : (1 << 30);
            if (c_done <= c_to) begin
                c_exit = c_done; to_e = 1'b0; mask_e = en;
            end else begin
                c_exit = c_to; to_e = 1'b1;
                mask_e = (c_to >= k) ? (dmask & en) : 5'd0;
            end
        end
        dur_e = 28'(c_exit);
        if (clr_cyc >= 1 && clr_cyc <= c_exit) begin
            seq_err_m = 1'b0; to_err_m = 1'b0; armed_m = 1'b0;
        end
        if (to_e) to_err_m = 1'b1;
        rec_e = {to_e, gap_e, mask_e, word[28:24], word[23:0], dur_e};

        @(negedge clk);
        evt_data = word; evt_valid = 1'b1; chan_en = en;
        readout_timeout = tmo; rd_done = '0;
        #1;
        got = 0;
        for (int w = 0; w < 20; w++) begin
            if (evt_ready === 1'b1) begin got = 1; break; end
            @(negedge clk); #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s pop: evt_ready=%b required 1", tag, evt_ready);
            evt_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        evt_valid = 1'b0;
        evt_data  = $urandom;
        chan_en   = 5'($urandom);   // must not affect the event in flight
        got = 0;
        for (i = 1; i <= 400; i++) begin
            rd_done   = ((i >= k) ? dmask : 5'd0) | (~en & 5'($urandom));
            err_clear = (i == clr_cyc);
            #1;
            if (info_valid === 1'b1) begin got = 1; break; end
            checks++;
            if (rd_req !== en) begin
                errors++;
                $display("FAIL %s rd_req cyc%0d: got %h required %h", tag, i, rd_req, en);
            end
            @(negedge clk);
        end
        err_clear = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s info_valid: got 0 required 1 within 400 cycles", tag);
            return;
        end
        checks++;
        if (i - 1 != c_exit) begin
            errors++;
            $display("FAIL %s readout_cycles: got %0d required %0d", tag, i - 1, c_exit);
        end
        checks++;
        if (info_data !== rec_e) begin
            errors++;
            $display("FAIL %s info_data: got %h required %h", tag, info_data, rec_e);
        end
        checks++;
        if (rd_req !== 5'd0 || state !== 3'b100) begin
            errors++;
            $display("FAIL %s emit_state: rd_req=%h state=%b required 00 100", tag, rd_req, state);
        end
        checks++;
        if (seq_err !== seq_err_m || timeout_err !== to_err_m) begin
            errors++;
            $display("FAIL %s sticky: seq_err=%b timeout_err=%b required %b %b",
                     tag, seq_err, timeout_err, seq_err_m, to_err_m);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            checks++;
            if (info_valid !== 1'b1 || info_data !== rec_e) begin
                errors++;
                $display("FAIL %s hold%0d: valid=%b data=%h required 1 %h",
                         tag, h, info_valid, info_data, rec_e);
            end
        end
        info_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        info_ready = 1'b0;
        count_m = count_m + 24'd1;
        #1;
        checks++;
        if (evt_count !== count_m || info_valid !== 1'b0 || state !== 3'b001) begin
            errors++;
            $display("FAIL %s accept: count=%0d valid=%b state=%b required %0d 0 001",
                     tag, evt_count, info_valid, state, count_m);
        end
        $display("evt %s num=%h type=%h rec=%h", tag, word[23:0], word[28:24], rec_e);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        seq_err_m = 1'b0; to_err_m = 1'b0; armed_m = 1'b0;
        #1;
        checks++;
        if (seq_err !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s clear: seq_err=%b timeout_err=%b required 0 0", tag, seq_err, timeout_err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; evt_valid = 1'b1; evt_data = 32'h0000_0001; chan_en = 5'h1F;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (state !== 3'b001 || evt_ready !== 1'b0 || rd_req !== 5'd0 || info_valid !== 1'b0 ||
            info_data !== 64'd0 || seq_err !== 1'b0 || timeout_err !== 1'b0 || evt_count !== 24'd0) begin
            errors++;
            $display("FAIL reset: state=%b rdy=%b req=%h iv=%b id=%h se=%b te=%b cnt=%0d required 001 0 00 0 0 0 0 0",
                     state, evt_ready, rd_req, info_valid, info_data, seq_err, timeout_err, evt_count);
        end
        evt_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        run_event(32'h0301_0005, 5'h1F, 24'd100, 5'h1F, 10, 2, 0, "basic");
        checks++;
        if (evt_count !== 24'd1) begin
            errors++;
            $display("FAIL basic_count: got %0d required 1", evt_count);
        end
    endtask

    task automatic test_timeout();
        run_event({8'h02, prev_m + 24'd1}, 5'h1F, 24'd8, 5'h0F, 1, 0, 0, "timeout");
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b required 1", timeout_err);
        end
        do_clear("timeout");
        // Completion and timeout in the same cycle: completion wins.
        run_event({8'h01, prev_m + 24'd1}, 5'h1F, 24'd6, 5'h1F, 6, 0, 0, "tie");
        // err_clear in the very cycle the timeout exit is taken: flag stays set.
        run_event({8'h01, prev_m + 24'd1}, 5'h13, 24'd4, 5'h03, 1, 0, 4, "clr_vs_to");
        do_clear("timeout2");
    endtask

    task automatic test_seq_gap();
        run_event(32'h0000_0007, 5'h1F, 24'd50, 5'h1F, 2, 0, 0, "seq7");
        run_event(32'h0000_0008, 5'h1F, 24'd50, 5'h1F, 2, 0, 0, "seq8");
        run_event(32'h0000_000A, 5'h1F, 24'd50, 5'h1F, 2, 0, 0, "seq10");
        checks++;
        if (seq_err !== SEQ_ON) begin
            errors++;
            $display("FAIL seq_err: got %b required %b", seq_err, SEQ_ON);
        end
        do_clear("seq");
        run_event(32'h0000_0014, 5'h1F, 24'd50, 5'h1F, 1, 0, 0, "seq20");
    endtask

    task automatic test_wrap();
        run_event(32'h04FF_FFFF, 5'h05, 24'd0, 5'h05, 3, 0, 0, "wrapF");
        run_event(32'h0400_0000, 5'h05, 24'd0, 5'h05, 1, 0, 0, "wrap0");
    endtask

    task automatic test_no_chan();
        run_event({8'h1F, prev_m + 24'd1}, 5'h00, 24'd5, 5'h1F, 1, 1, 0, "nochan");
    endtask

    task automatic test_backpressure();
        logic [31:0] q[3];
        logic [63:0] rec_q[3];
        logic [63:0] snap;
        int qi, ri, pulses;
        bit seen, unstable, pop_now;
        logic g;
        for (int j = 0; j < 3; j++) begin
            q[j] = {3'b0, 5'($urandom), prev_m + 24'd1 + ((j == 2) ? 24'd3 : 24'd0)};
            g = seq_step(q[j][23:0]);
            rec_q[j] = {1'b0, g, 5'h1F, q[j][28:24], q[j][23:0], 28'd1};
        end
        chan_en = 5'h1F; rd_done = 5'h1F; readout_timeout = 24'd0;
        qi = 0; ri = 0; pulses = 0; seen = 0; unstable = 0; snap = '0;
        for (int cyc = 0; cyc < 130 && ri < 3; cyc++) begin
            @(negedge clk);
            evt_valid  = (qi < 3);
            evt_data   = (qi < 3) ? q[qi] : 32'd0;
            info_ready = (cyc >= 50);
            #1;
            pop_now = (evt_ready === 1'b1);
            if (pop_now && cyc < 50) pulses++;
            if (info_valid === 1'b1) begin
                if (cyc < 50) begin
                    if (!seen) begin seen = 1; snap = info_data; end
                    else if (info_data !== snap) unstable = 1;
                end else begin
                    checks++;
                    if (info_data !== rec_q[ri]) begin
                        errors++;
                        $display("FAIL bp_rec%0d: got %h required %h", ri, info_data, rec_q[ri]);
                    end
                    $display("evt bp%0d rec=%h", ri, rec_q[ri]);
                    ri++;
                    count_m = count_m + 24'd1;
                end
            end
            if (pop_now) qi++;
        end
        @(negedge clk);
        evt_valid = 1'b0; info_ready = 1'b0; rd_done = '0;
        #1;
        checks++;
        if (pulses != 1 || unstable || !seen) begin
            errors++;
            $display("FAIL bp_stall: pops=%0d unstable=%b seen=%b required 1 0 1", pulses, unstable, seen);
        end
        checks++;
        if (ri != 3 || evt_count !== count_m) begin
            errors++;
            $display("FAIL bp_drain: records=%0d count=%0d required 3 %0d", ri, evt_count, count_m);
        end
    endtask

    task automatic test_reset_mid();
        bit bad;
        @(negedge clk);
        evt_data = {8'h03, prev_m + 24'd1}; evt_valid = 1'b1;
        chan_en = 5'h1F; readout_timeout = 24'd0; rd_done = '0;
        @(negedge clk);
        evt_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rd_req !== 5'h1F) begin
            errors++;
            $display("FAIL rmid_readout: rd_req=%h required 1f", rd_req);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (rd_req !== 5'd0 || state !== 3'b001 || info_valid !== 1'b0 || evt_count !== 24'd0) begin
            errors++;
            $display("FAIL rmid_async: req=%h state=%b iv=%b cnt=%0d required 00 001 0 0",
                     rd_req, state, info_valid, evt_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        rd_done = 5'h1F;
        bad = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (info_valid !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL rmid_no_record: info_valid=1 required 0");
        end
        run_event({8'h02, prev_m + 24'd9}, 5'h1F, 24'd20, 5'h1F, 2, 0, 0, "after_rst");
    endtask

    task automatic test_random();
        logic [4:0]  en, dm;
        logic [23:0] tmo, num;
        for (int n = 0; n < 40; n++) begin
            en  = 5'($urandom);
            tmo = 24'($urandom_range(0, 20));
            dm  = (($urandom % 3) == 0) ? 5'($urandom) : (en | 5'($urandom));
            if (tmo == 24'd0) dm = dm | en;
            num = (($urandom % 4) == 0) ? 24'($urandom) : prev_m + 24'd1;
            run_event({3'($urandom), 5'($urandom), num}, en, tmo, dm,
                      $urandom_range(1, 15), $urandom_range(0, 3), 0, $sformatf("rnd%0d", n));
            if (($urandom % 8) == 0) do_clear($sformatf("rnd%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_seq_gap();
        test_wrap();
        test_no_chan();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
